// File: rtl/gerador_permutacao_param.sv
// Decodes a rank in 0..N!-1 into the rank-th lexicographic permutation of {0..N-1}
// (or its inverse), one factoradic digit per clock behind a start/ready/valid handshake.
module gerador_permutacao_param #(
  parameter int unsigned N   = 4,
  parameter int unsigned K_W = 16,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [K_W-1:0]  entrada,
  input  logic            modo,
  output logic [N*IW-1:0] perm,
  output logic            ready,
  output logic            valid,
  output logic            erro
);

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] CALCULA = 2'd1;
  localparam logic [1:0] PRONTO  = 2'd2;

  // Elaboration-time factorial; every call site has a constant argument.
  function automatic int unsigned fact_c(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned k = 2; k <= 8; k++) begin
      if (k <= n) r = r * k;
    end
    return r;
  endfunction

  localparam int unsigned NFACT = fact_c(N);

  logic [1:0]      state, state_d;
  logic [K_W-1:0]  rem, rem_d;
  logic [IW-1:0]   pool [N];
  logic [IW-1:0]   pool_d [N];
  logic [IW-1:0]   res [N];
  logic [IW-1:0]   res_d [N];
  logic [IW-1:0]   step, step_d;
  logic            modo_q, modo_d;
  logic [N*IW-1:0] perm_d;
  logic            erro_d, valid_d, ready_d;

  int unsigned     thresh [N];
  logic [IW-1:0]   d, sel;
  logic [IW-1:0]   inv [N];

  // Digit extraction: thresholds k*(N-1-step)! are constants muxed by step.
  always_comb begin
    for (int unsigned k = 0; k < N; k++) thresh[k] = 0;
    for (int unsigned j = 0; j < N; j++) begin
      if (32'(step) == j) begin
        for (int unsigned k = 0; k < N; k++) thresh[k] = fact_c(N - 1 - j) * k;
      end
    end
    d = '0;
    for (int unsigned k = 1; k < N; k++) begin
      if (32'(rem) >= thresh[k]) d = IW'(k);
    end
    sel = pool[d];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state;
    rem_d   = rem;
    pool_d  = pool;
    res_d   = res;
    step_d  = step;
    modo_d  = modo_q;
    perm_d  = perm;
    erro_d  = erro;
    for (int unsigned i = 0; i < N; i++) inv[i] = '0;

    case (state)
      OCIOSO: begin
        if (start) begin
          modo_d = modo;
          if (64'(entrada) >= 64'(NFACT)) begin
            erro_d  = 1'b1;
            perm_d  = '0;
            state_d = PRONTO;
          end else begin
            erro_d = 1'b0;
            rem_d  = entrada;
            for (int unsigned j = 0; j < N; j++) pool_d[j] = IW'(j);
            step_d  = '0;
            state_d = CALCULA;
          end
        end
      end
      CALCULA: begin
        rem_d       = rem - K_W'(thresh[d]);
        res_d[step] = sel;
        // Remove the chosen pool entry; entries above it shift down.
        for (int unsigned j = 0; j < N; j++) begin
          if (j < 32'(d))      pool_d[j] = pool[j];
          else if (j + 1 < N)  pool_d[j] = pool[(j + 1) % N];
          else                 pool_d[j] = '0;
        end
        step_d = step + IW'(1);
        if (32'(step) == N - 1) begin
          for (int unsigned i = 0; i < N; i++) inv[res_d[i]] = IW'(i);
          for (int unsigned p = 0; p < N; p++) begin
            perm_d[(N - p) * IW - 1 -: IW] = modo_q ? inv[p] : res_d[p];
          end
          state_d = PRONTO;
        end
      end
      PRONTO:  state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase

    ready_d = (state_d == OCIOSO);
    valid_d = (state_d == PRONTO);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= OCIOSO;
      rem    <= '0;
      pool   <= '{default: '0};
      res    <= '{default: '0};
      step   <= '0;
      modo_q <= 1'b0;
      perm   <= '0;
      erro   <= 1'b0;
      valid  <= 1'b0;
      ready  <= 1'b1;
    end else begin
      state  <= state_d;
      rem    <= rem_d;
      pool   <= pool_d;
      res    <= res_d;
      step   <= step_d;
      modo_q <= modo_d;
      perm   <= perm_d;
      erro   <= erro_d;
      valid  <= valid_d;
      ready  <= ready_d;
    end
  end

endmodule

// File: tb/tb_gerador_permutacao_param.sv
// Directed bench for gerador_permutacao_param: N=4 table vectors, multi-cycle corner
// sequences, an N=4 sweep against a next-permutation model, and N=8 endpoints.
module tb_gerador_permutacao_param;

  logic        clock, reset;
  logic        start4, modo4;
  logic [15:0] ent4;
  logic [7:0]  perm4;
  logic        ready4, valid4, erro4;
  logic        start8, modo8;
  logic [15:0] ent8;
  logic [23:0] perm8;
  logic        ready8, valid8, erro8;

  int tests, fails;
  logic [7:0] ref4 [24];

  gerador_permutacao_param #(.N(4), .K_W(16)) dut4 (
    .clock(clock), .reset(reset), .start(start4), .entrada(ent4), .modo(modo4),
    .perm(perm4), .ready(ready4), .valid(valid4), .erro(erro4));

  gerador_permutacao_param #(.N(8), .K_W(16)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .entrada(ent8), .modo(modo8),
    .perm(perm8), .ready(ready8), .valid(valid8), .erro(erro8));

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] entrada;
    logic        modo;
    logic [7:0]  exp_perm;
    logic        exp_erro;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Lexicographic reference built by repeated next-permutation from the identity.
  task automatic build_ref4();
    int a [4];
    int i, j, t;
    for (int k = 0; k < 4; k++) a[k] = k;
    for (int r = 0; r < 24; r++) begin
      ref4[r] = {2'(a[0]), 2'(a[1]), 2'(a[2]), 2'(a[3])};
      i = 2;
      while (i >= 0 && a[i] > a[i+1]) i--;
      if (i >= 0) begin
        j = 3;
        while (a[j] < a[i]) j--;
        t = a[i]; a[i] = a[j]; a[j] = t;
        for (int lo = i + 1, hi = 3; lo < hi; lo++, hi--) begin
          t = a[lo]; a[lo] = a[hi]; a[hi] = t;
        end
      end
    end
  endtask

  // Called #1 after a rising edge; lat = rising edges from accept edge to valid.
  task automatic run4(input logic [15:0] e, input logic m,
                      output logic [7:0] p, output logic er, output int lat);
    int guard;
    guard = 0;
    while (!ready4 && guard < 40) begin @(posedge clock); #1; guard++; end
    start4 = 1'b1; ent4 = e; modo4 = m;
    @(posedge clock); #1;
    start4 = 1'b0; ent4 = ~e; modo4 = ~m;
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      if (valid4) begin lat = c; break; end
      @(posedge clock); #1;
    end
    p = perm4; er = erro4;
    @(posedge clock); #1;
    chk("valid4_single_pulse", 32'(valid4), 32'd0);
  endtask

  task automatic run8(input logic [15:0] e, output logic [23:0] p,
                      output logic er, output int lat);
    int guard;
    guard = 0;
    while (!ready8 && guard < 40) begin @(posedge clock); #1; guard++; end
    start8 = 1'b1; ent8 = e; modo8 = 1'b0;
    @(posedge clock); #1;
    start8 = 1'b0; ent8 = ~e;
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      if (valid8) begin lat = c; break; end
      @(posedge clock); #1;
    end
    p = perm8; er = erro8;
    @(posedge clock); #1;
  endtask

  initial begin
    vec_t vecs [10];
    logic [7:0]  p;
    logic [23:0] p8;
    logic        er;
    int          lat, cnt, acc, nval, last_c, distinct;
    logic [255:0] seen;

    vecs[0] = '{16'd0,  1'b0, 8'h1B, 1'b0, 4};
    vecs[1] = '{16'd1,  1'b0, 8'h1E, 1'b0, 4};
    vecs[2] = '{16'd3,  1'b0, 8'h2D, 1'b0, 4};
    vecs[3] = '{16'd12, 1'b0, 8'h87, 1'b0, 4};
    vecs[4] = '{16'd23, 1'b0, 8'hE4, 1'b0, 4};
    vecs[5] = '{16'd24, 1'b0, 8'h00, 1'b1, 0};
    vecs[6] = '{16'd31, 1'b0, 8'h00, 1'b1, 0};
    vecs[7] = '{16'd0,  1'b0, 8'h1B, 1'b0, 4};
    vecs[8] = '{16'd12, 1'b1, 8'h63, 1'b0, 4};
    vecs[9] = '{16'd3,  1'b1, 8'h36, 1'b0, 4};

    tests = 0; fails = 0;
    clock = 1'b0; reset = 1'b0;
    start4 = 1'b0; ent4 = '0; modo4 = 1'b0;
    start8 = 1'b0; ent8 = '0; modo8 = 1'b0;
    build_ref4();

    @(posedge clock); @(posedge clock); #1;
    chk("reset_perm",  32'(perm4),  32'd0);
    chk("reset_valid", 32'(valid4), 32'd0);
    chk("reset_erro",  32'(erro4),  32'd0);
    chk("reset_ready", 32'(ready4), 32'd1);
    chk("reset_ready8", 32'(ready8), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;

    // Table vectors
    for (int v = 0; v < 10; v++) begin
      run4(vecs[v].entrada, vecs[v].modo, p, er, lat);
      chk($sformatf("vec%0d_perm", v), 32'(p),  32'(vecs[v].exp_perm));
      chk($sformatf("vec%0d_erro", v), 32'(er), 32'(vecs[v].exp_erro));
      chk($sformatf("vec%0d_lat", v),  32'(lat), 32'(vecs[v].exp_lat));
    end

    // Reset asserted mid-computation
    run4(16'd23, 1'b0, p, er, lat);
    start4 = 1'b1; ent4 = 16'd5;
    @(posedge clock); #1;
    start4 = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("abort_perm",  32'(perm4),  32'd0);
    chk("abort_valid", 32'(valid4), 32'd0);
    chk("abort_erro",  32'(erro4),  32'd0);
    chk("abort_ready", 32'(ready4), 32'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      if (valid4) cnt++;
    end
    chk("abort_no_valid", 32'(cnt), 32'd0);

    // start held high, entrada changing every cycle
    start4 = 1'b1; modo4 = 1'b0; acc = 0; nval = 0; last_c = -1;
    for (int c = 0; c < 40 && nval < 3; c++) begin
      ent4 = 16'((c * 7 + 3) % 24);
      if (ready4) acc = (c * 7 + 3) % 24;
      if (valid4) begin
        chk("held_perm", 32'(perm4), 32'(ref4[acc]));
        if (last_c >= 0) chk("held_spacing", 32'(c - last_c), 32'd6);
        last_c = c;
        nval++;
      end
      @(posedge clock); #1;
    end
    start4 = 1'b0;
    chk("held_pulses", 32'(nval), 32'd3);
    @(posedge clock); #1;

    // start pulse during computation is ignored, not queued
    start4 = 1'b1; ent4 = 16'd3; modo4 = 1'b0;
    @(posedge clock); #1;
    start4 = 1'b0;
    @(posedge clock); #1;
    start4 = 1'b1; ent4 = 16'd23;
    @(posedge clock); #1;
    start4 = 1'b0;
    for (int c = 0; c < 40 && !valid4; c++) begin @(posedge clock); #1; end
    chk("ignored_valid", 32'(valid4), 32'd1);
    chk("ignored_perm",  32'(perm4),  32'h2D);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); #1;
      if (valid4) cnt++;
    end
    chk("ignored_not_queued", 32'(cnt), 32'd0);
    chk("hold_perm", 32'(perm4), 32'h2D);

    // Exhaustive N=4 sweep
    seen = '0; distinct = 0;
    for (int r = 0; r < 24; r++) begin
      run4(16'(r), 1'b0, p, er, lat);
      chk($sformatf("sweep%0d", r), 32'(p), 32'(ref4[r]));
      if (!seen[p]) distinct++;
      seen[p] = 1'b1;
    end
    chk("sweep_distinct", 32'(distinct), 32'd24);

    // N=8 endpoints
    run8(16'd0, p8, er, lat);
    chk("n8_first_perm", 32'(p8), 32'h053977);
    chk("n8_first_lat",  32'(lat), 32'd8);
    run8(16'd40319, p8, er, lat);
    chk("n8_last_perm", 32'(p8), 32'hFAC688);
    chk("n8_last_erro", 32'(er), 32'd0);
    run8(16'd40320, p8, er, lat);
    chk("n8_range_erro", 32'(er), 32'd1);
    chk("n8_range_perm", 32'(p8), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
